// File: rtl/morse_pkg.sv
// morse_pkg: shared types and default timing for the Morse press classifier.
//   sym_code_e  : symbol encoding driven on sym_code (DOT, DASH, LETTER_END, WORD_END)
//   cls_state_e : classifier FSM states
//   Default*    : default tick counts at a 100 MHz clock
package morse_pkg;

    typedef enum logic [1:0] {
        SymDot       = 2'b00,
        SymDash      = 2'b01,
        SymLetterEnd = 2'b10,
        SymWordEnd   = 2'b11
    } sym_code_e;

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StGap
    } cls_state_e;

    localparam int unsigned DefaultDotMaxTicks    = 32'd20_000_000;   // 200 ms
    localparam int unsigned DefaultLetterGapTicks = 32'd60_000_000;   // 600 ms
    localparam int unsigned DefaultWordGapTicks   = 32'd140_000_000;  // 1400 ms
    localparam int unsigned SymFifoDepth          = 4;

endpackage

// File: rtl/sym_fifo.sv
// sym_fifo: small first-word-fall-through FIFO for classified symbols.
// Ports:
//   clk_100Mhz  in   clock, rising edge
//   reset       in   asynchronous active-high reset, empties the FIFO
//   push        in   write request; ignored when full unless a pop happens the same cycle
//   push_data   in   Width-bit entry to write
//   pop         in   read request; ignored when empty
//   pop_data    out  head entry, valid whenever empty is low (zero when empty)
//   empty, full out  occupancy flags
module sym_fifo #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_100Mhz,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CntW'(Depth));
    assign do_pop   = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/press_classifier.sv
// press_classifier: turns a debounced button level into Morse symbols.
// Press length picks DOT/DASH; release length emits LETTER_END then WORD_END.
// Ports:
//   clk_100Mhz  in   sole clock, rising edge
//   reset       in   asynchronous active-high reset
//   btn_press   in   debounced synchronous button level
//   sym_valid   out  symbol available
//   sym_ready   in   consumer accepts symbol (transfer on sym_valid & sym_ready)
//   sym_code    out  00 DOT, 01 DASH, 10 LETTER_END, 11 WORD_END
//   sym_drop    out  one-cycle pulse when a symbol is lost to full storage
// Build option: define MORSE_SYM_FIFO_EN for a 4-entry FIFO of pending symbols;
// otherwise a single output register holds one symbol.
module press_classifier
    import morse_pkg::*;
#(
    parameter int unsigned DOT_MAX_TICKS    = DefaultDotMaxTicks,
    parameter int unsigned LETTER_GAP_TICKS = DefaultLetterGapTicks,
    parameter int unsigned WORD_GAP_TICKS   = DefaultWordGapTicks
) (
    input  logic       clk_100Mhz,
    input  logic       reset,
    input  logic       btn_press,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [1:0] sym_code,
    output logic       sym_drop
);

    localparam int unsigned CntW = $clog2(WORD_GAP_TICKS + 1);

    cls_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]     cnt_ext, inc_ext;
    logic            prod;
    sym_code_e       prod_code;
    logic            pop, full, drop_q;

    // Saturate rather than wrap so an over-long press still reads as DASH.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CntW'(1);
    assign cnt_ext = 32'(cnt_q);
    assign inc_ext = 32'(cnt_inc);

    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod      = 1'b0;
        prod_code = SymDot;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (btn_press) begin
                    state_d = StPress;
                    cnt_d   = CntW'(1);
                end
            end
            StPress: begin
                if (btn_press) begin
                    cnt_d = cnt_inc;
                end else begin
                    prod      = 1'b1;
                    prod_code = (cnt_ext < DOT_MAX_TICKS) ? SymDot : SymDash;
                    state_d   = StGap;
                    cnt_d     = CntW'(1);
                end
            end
            StGap: begin
                if (btn_press) begin
                    state_d = StPress;
                    cnt_d   = CntW'(1);
                end else begin
                    cnt_d = cnt_inc;
                    // The count passes each threshold once, so each gap symbol fires once.
                    if (inc_ext == LETTER_GAP_TICKS) begin
                        prod      = 1'b1;
                        prod_code = SymLetterEnd;
                    end
                    if (inc_ext == WORD_GAP_TICKS) begin
                        prod      = 1'b1;
                        prod_code = SymWordEnd;
                        state_d   = StIdle;
                        cnt_d     = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign pop = sym_valid & sym_ready;

`ifdef MORSE_SYM_FIFO_EN
    logic       fifo_empty;
    logic [1:0] fifo_data;

    sym_fifo #(
        .Width (2),
        .Depth (SymFifoDepth)
    ) u_sym_fifo (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .push       (prod),
        .push_data  (prod_code),
        .pop        (pop),
        .pop_data   (fifo_data),
        .empty      (fifo_empty),
        .full       (full)
    );

    assign sym_valid = ~fifo_empty;
    assign sym_code  = fifo_data;
`else
    logic       valid_q;
    logic [1:0] code_q;

    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            code_q  <= 2'b00;
        end else if (prod && (!valid_q || pop)) begin
            valid_q <= 1'b1;
            code_q  <= prod_code;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign full      = valid_q;
    assign sym_valid = valid_q;
    assign sym_code  = code_q;
`endif

    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) drop_q <= 1'b0;
        else       drop_q <= prod & full & ~pop;
    end

    assign sym_drop = drop_q;

endmodule

// File: tb/tb_press_classifier.sv
`timescale 1ns/1ps
module tb_press_classifier;

    localparam int DotMax    = 4;
    localparam int LetterGap = 8;
    localparam int WordGap   = 16;
`ifdef MORSE_SYM_FIFO_EN
    localparam int Cap = 4;
`else
    localparam int Cap = 1;
`endif
    localparam logic [1:0] CDot = 2'b00, CDash = 2'b01, CLe = 2'b10, CWe = 2'b11;

    logic       clk_100Mhz = 1'b0;
    logic       reset, btn_press, sym_ready;
    logic       sym_valid, sym_drop;
    logic [1:0] sym_code;

    press_classifier #(
        .DOT_MAX_TICKS    (DotMax),
        .LETTER_GAP_TICKS (LetterGap),
        .WORD_GAP_TICKS   (WordGap)
    ) dut (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .btn_press  (btn_press),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_code   (sym_code),
        .sym_drop   (sym_drop)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    int n_cmp = 0, n_fail = 0;

    // Behavioural model: run lengths of press/release plus a bounded symbol queue.
    logic [1:0] mq[$];
    int         press_len, gap_len;
    bit         pressing, gapping, exp_drop;

    typedef struct {logic [1:0] code; int cyc;} xfer_t;
    xfer_t      got[$];
    int         cyc = 0, drop_cnt = 0;
    logic       seen_valid;
    logic [1:0] seen_code;

    function void model_clear();
        mq.delete();
        pressing = 0; gapping = 0; press_len = 0; gap_len = 0;
        exp_drop = 0; seen_valid = 0; seen_code = 2'b00;
    endfunction

    function void emit(input logic [1:0] c);
        if (mq.size() < Cap) mq.push_back(c);
        else exp_drop = 1;
    endfunction

    function void model_step(input logic b, input logic r);
        exp_drop = 0;
        if (mq.size() > 0 && r) void'(mq.pop_front());
        if (pressing) begin
            if (b) press_len++;
            else begin
                emit((press_len < DotMax) ? CDot : CDash);
                pressing = 0; gapping = 1; gap_len = 1;
            end
        end else if (gapping) begin
            if (b) begin
                gapping = 0; pressing = 1; press_len = 1;
            end else begin
                gap_len++;
                if (gap_len == LetterGap) emit(CLe);
                if (gap_len == WordGap) begin
                    emit(CWe);
                    gapping = 0;
                end
            end
        end else if (b) begin
            pressing = 1; press_len = 1;
        end
    endfunction

    // Per-cycle compare against the model, plus a log of accepted symbols.
    always @(posedge clk_100Mhz) begin
        logic       ev;
        logic [1:0] ec;
        if (reset) begin
            model_clear();
        end else begin
            if (seen_valid && sym_ready) got.push_back('{code: seen_code, cyc: cyc});
            model_step(btn_press, sym_ready);
            cyc++;
            #1;
            ev = (mq.size() > 0);
            ec = ev ? mq[0] : 2'b00;
            n_cmp++;
            if (sym_valid !== ev || (ev && sym_code !== ec) || sym_drop !== exp_drop) begin
                n_fail++;
                $display("FAIL cycle %0d outputs: got v=%b c=%b d=%b, expected v=%b c=%b d=%b",
                         cyc, sym_valid, sym_code, sym_drop, ev, ec, exp_drop);
            end
            seen_valid = sym_valid;
            seen_code  = sym_code;
            if (sym_drop) drop_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int got_codes();
        int v = 0;
        foreach (got[i]) v = (v << 2) | int'(got[i].code);
        return v;
    endfunction

    function automatic int got_cyc(input int i);
        return (i < got.size()) ? got[i].cyc : -1000;
    endfunction

    task automatic drive(input logic b, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_100Mhz);
            btn_press = b;
            sym_ready = r;
        end
    endtask

    task automatic start_test();
        got.delete();
        drop_cnt = 0;
    endtask

    initial begin
        reset = 1'b1; btn_press = 1'b0; sym_ready = 1'b1;
        model_clear();
        @(posedge clk_100Mhz); #1;
        chk("reset_valid", sym_valid, 0);
        chk("reset_code", sym_code, 0);
        chk("reset_drop", sym_drop, 0);
        @(negedge clk_100Mhz); reset = 1'b0;

        // Short press: DOT one cycle after release, then gap symbols.
        start_test();
        drive(1, 1, 3);
        drive(0, 1, 1);
        @(posedge clk_100Mhz); #2;
        chk("t1_dot_valid", sym_valid, 1);
        chk("t1_dot_code", sym_code, CDot);
        drive(0, 1, 19);
        chk("t1_count", got.size(), 3);
        chk("t1_codes", got_codes(), 11);
        chk("t1_le_delay", got_cyc(1) - got_cyc(0), 7);
        chk("t1_we_delay", got_cyc(2) - got_cyc(0), 15);

        // Threshold boundary: 4 -> DASH, 3 -> DOT.
        start_test();
        drive(1, 1, 4); drive(0, 1, 20);
        chk("t2_codes", got_codes(), 27);
        chk("t2_count", got.size(), 3);
        start_test();
        drive(1, 1, 3); drive(0, 1, 20);
        chk("t3_codes", got_codes(), 11);

        // Short gap between presses emits no LETTER_END.
        start_test();
        drive(1, 1, 2); drive(0, 1, 3); drive(1, 1, 6); drive(0, 1, 20);
        chk("t4_count", got.size(), 4);
        chk("t4_codes", got_codes(), 27);

        // Press longer than the counter range still classifies as DASH.
        start_test();
        drive(1, 1, 33); drive(0, 1, 20);
        chk("t5_codes", got_codes(), 27);

        // Back-pressure: DOT held while LETTER_END arrives.
        start_test();
        drive(1, 0, 2); drive(0, 0, 10);
        chk("t6_drops", drop_cnt, (Cap == 1) ? 1 : 0);
        drive(0, 1, 20);
        chk("t6_count", got.size(), (Cap == 1) ? 2 : 3);
        chk("t6_codes", got_codes(), (Cap == 1) ? 3 : 11);

        // Produce and pop in the same cycle: nothing dropped.
        start_test();
        drive(1, 0, 1); drive(0, 0, 1); drive(1, 0, 1); drive(0, 1, 1); drive(0, 1, 20);
        chk("t7_drops", drop_cnt, 0);
        chk("t7_count", got.size(), 4);
        chk("t7_codes", got_codes(), 11);

        // Asynchronous reset mid-press with a symbol pending.
        start_test();
        drive(1, 0, 2); drive(0, 0, 1); drive(1, 0, 2);
        @(posedge clk_100Mhz); #2;
        chk("t8_valid_before", sym_valid, 1);
        #1 reset = 1'b1;
        #1;
        chk("t8_valid_async", sym_valid, 0);
        chk("t8_code_async", sym_code, 0);
        chk("t8_drop_async", sym_drop, 0);
        @(negedge clk_100Mhz); btn_press = 1'b0; sym_ready = 1'b1;
        @(negedge clk_100Mhz); reset = 1'b0;
        start_test();
        drive(0, 1, 20);
        chk("t8_no_symbols", got.size(), 0);
        chk("t8_valid_after", sym_valid, 0);

        // Button already high at reset release counts from the first sample.
        @(negedge clk_100Mhz); reset = 1'b1; btn_press = 1'b1; sym_ready = 1'b1;
        @(negedge clk_100Mhz); reset = 1'b0;
        start_test();
        drive(1, 1, 3); drive(0, 1, 20);
        chk("t9_codes", got_codes(), 27);
        chk("t9_count", got.size(), 3);

        drive(0, 1, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
